// File: rtl/img_downscale_28.sv
// Crops an N_BLK*16 square window out of a camera stream and emits one 16x16 block average per block
// in raster order (28x28 outputs for the default 448x448 crop), with a one-cycle frame-done pulse.
module img_downscale_28 #(
  parameter int X_START = 96,
  parameter int Y_START = 16,
  parameter int N_BLK   = 28
) (
  input  logic        pxlclk,
  input  logic        rst_n,
  input  logic        iFVAL,
  input  logic        iLVAL,
  input  logic        iDVAL,
  input  logic [11:0] iDATA,
  output logic        oFVAL,
  output logic        oDVAL,
  output logic [15:0] oDATA,
  output logic        oFRAME_DONE
);

  localparam int          WIN      = 16 * N_BLK;
  localparam int          BW       = (N_BLK > 1) ? $clog2(N_BLK) : 1;
  localparam logic [11:0] X_LO     = 12'(X_START);
  localparam logic [11:0] X_HI     = 12'(X_START + WIN);
  localparam logic [10:0] Y_LO     = 11'(Y_START);
  localparam logic [10:0] Y_HI     = 11'(Y_START + WIN);
  localparam logic [9:0]  OUT_MAX  = 10'(N_BLK * N_BLK);
  localparam logic [9:0]  OUT_LAST = 10'(N_BLK * N_BLK - 1);

  logic        fval_q, fval_d, lval_q, lval_d;
  logic        known_q, known_d, active_q, active_d;
  logic [11:0] col_q, col_d;
  logic [10:0] line_q, line_d;
  logic [19:0] acc_q [N_BLK];
  logic [19:0] acc_d [N_BLK];
  logic [9:0]  out_cnt_q, out_cnt_d;
  logic        dval_q, dval_d, done_q, done_d;
  logic [11:0] data_q, data_d;

  logic        fval_rise, lval_fall, pix, in_win, take, corner;
  logic [11:0] wx;
  logic [10:0] wy;
  logic [BW-1:0] bx;
  logic [19:0] sum;

  // known_q keeps a frame already running at reset release from looking like a fresh rising edge.
  assign fval_rise = iFVAL & ~fval_q & known_q;
  assign lval_fall = lval_q & ~iLVAL;
  assign pix       = iFVAL & iLVAL & iDVAL;
  assign in_win    = (col_q >= X_LO) && (col_q < X_HI) && (line_q >= Y_LO) && (line_q < Y_HI);
  assign wx        = col_q - X_LO;
  assign wy        = line_q - Y_LO;
  assign bx        = BW'(wx >> 4);
  assign take      = pix & in_win & active_q & (out_cnt_q != OUT_MAX);
  assign corner    = take && ((wx & 12'hF) == 12'hF) && ((wy & 11'hF) == 11'hF);
  assign sum       = acc_q[bx] + {8'b0, iDATA};

  // NOTE: every always_comb output gets a default first, so no path leaves a value held (no latches).
  always_comb begin
    fval_d    = iFVAL;
    lval_d    = iLVAL;
    known_d   = 1'b1;
    active_d  = active_q;
    col_d     = col_q;
    line_d    = line_q;
    acc_d     = acc_q;
    out_cnt_d = out_cnt_q;
    dval_d    = 1'b0;
    done_d    = 1'b0;
    data_d    = data_q;

    if (fval_rise || lval_fall) col_d = '0;
    else if (pix)               col_d = col_q + 12'd1;

    if (fval_rise)                line_d = '0;
    else if (lval_fall && iFVAL)  line_d = line_q + 11'd1;

    // A new frame wipes all partial sums; this wins over any accumulate in the same cycle.
    if (fval_rise) begin
      active_d  = 1'b1;
      out_cnt_d = '0;
      for (int i = 0; i < N_BLK; i++) acc_d[i] = '0;
    end else if (take) begin
      if (corner) begin
        acc_d[bx] = '0;
        dval_d    = 1'b1;
        data_d    = 12'(sum >> 8);
        out_cnt_d = out_cnt_q + 10'd1;
        done_d    = (out_cnt_q == OUT_LAST);
      end else begin
        acc_d[bx] = sum;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge pxlclk or negedge rst_n) begin
    if (!rst_n) begin
      fval_q    <= 1'b0;
      lval_q    <= 1'b0;
      known_q   <= 1'b0;
      active_q  <= 1'b0;
      col_q     <= '0;
      line_q    <= '0;
      out_cnt_q <= '0;
      dval_q    <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
      // NOTE: the accumulator array is reset with the rest of the state so an aborted frame leaves no sums behind.
      for (int i = 0; i < N_BLK; i++) acc_q[i] <= '0;
    end else begin
      fval_q    <= fval_d;
      lval_q    <= lval_d;
      known_q   <= known_d;
      active_q  <= active_d;
      col_q     <= col_d;
      line_q    <= line_d;
      out_cnt_q <= out_cnt_d;
      dval_q    <= dval_d;
      done_q    <= done_d;
      data_q    <= data_d;
      acc_q     <= acc_d;
    end
  end

  assign oFVAL       = fval_q;
  assign oDVAL       = dval_q;
  assign oDATA       = {4'b0, data_q};
  assign oFRAME_DONE = done_q;

endmodule

// File: tb/tb_img_downscale_28.sv
// Bench for img_downscale_28 on a reduced 4x4-block window; expectations come from whole-frame block sums.
`timescale 1ns/1ps
module tb_img_downscale_28;

  localparam int X  = 6;
  localparam int Y  = 3;
  localparam int NB = 4;
  localparam int FW = 72;
  localparam int FH = 68;

  typedef enum int {K_CONST, K_BX, K_FFF, K_ALT, K_RAND} kind_e;
  typedef struct {
    kind_e kind;
    int    line_len;
    int    n_lines;
    int    gap;
    int    exp_strobes;
    int    exp_done;
  } vec_t;

  logic        pxlclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        iFVAL = 1'b0, iLVAL = 1'b0, iDVAL = 1'b0;
  logic [11:0] iDATA = '0;
  logic        oFVAL, oDVAL, oFRAME_DONE;
  logic [15:0] oDATA;

  int tests = 0;
  int fails = 0;

  logic [11:0] img [FH][FW];
  logic [11:0] exp_q [$];
  logic drv_corner = 1'b0, drv_done = 1'b0;
  logic exp_dval_s = 1'b0, exp_done_s = 1'b0, exp_fval_s = 1'b0;
  logic mon_en = 1'b0;
  int   got_strobes = 0, got_done = 0;

  img_downscale_28 #(.X_START(X), .Y_START(Y), .N_BLK(NB)) dut (
    .pxlclk(pxlclk), .rst_n(rst_n), .iFVAL(iFVAL), .iLVAL(iLVAL), .iDVAL(iDVAL), .iDATA(iDATA),
    .oFVAL(oFVAL), .oDVAL(oDVAL), .oDATA(oDATA), .oFRAME_DONE(oFRAME_DONE)
  );

  always #5 pxlclk = ~pxlclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge pxlclk);
    #1;
  endtask

  // Expected timing: whatever the driver presented at an edge shows up on the outputs one cycle later.
  always @(posedge pxlclk) begin
    exp_dval_s <= drv_corner;
    exp_done_s <= drv_done;
    exp_fval_s <= rst_n ? iFVAL : 1'b0;
  end

  always @(negedge pxlclk) begin
    if (mon_en) begin
      check("dval", oDVAL, exp_dval_s);
      check("fval", oFVAL, exp_fval_s);
      check("frame_done", oFRAME_DONE, exp_done_s);
      if (oDVAL) begin
        got_strobes++;
        if (oFRAME_DONE) got_done++;
        if (exp_q.size() == 0) check("unexpected_strobe", 1, 0);
        else check("data", oDATA, {4'b0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [11:0] gen_pix(input kind_e k, input int l, input int c);
    int wx = c - X;
    int wy = l - Y;
    bit inw = (wx >= 0) && (wx < 16 * NB) && (wy >= 0) && (wy < 16 * NB);
    case (k)
      K_CONST: return 12'h800;
      K_BX:    return inw ? 12'(wx / 16) : 12'hFFF;
      K_FFF:   return 12'hFFF;
      K_ALT:   return (c % 2 == 1) ? 12'h00F : 12'h000;
      default: return 12'($urandom_range(4095));
    endcase
  endfunction

  task automatic do_reset();
    mon_en     = 1'b0;
    drv_corner = 1'b0;
    drv_done   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_fval", oFVAL, 0);
    check("rst_dval", oDVAL, 0);
    check("rst_data", oDATA, 0);
    check("rst_done", oFRAME_DONE, 0);
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    mon_en = 1'b1;
  endtask

  task automatic run_frame(input vec_t v, input int abort_line, input string name);
    int  corners = 0;
    bit  live = 1'b1;
    for (int l = 0; l < FH; l++)
      for (int c = 0; c < FW; c++) img[l][c] = gen_pix(v.kind, l, c);
    // Reference: a block yields one output, its plain 256-pixel sum >> 8, iff its last pixel is driven.
    for (int by = 0; by < NB; by++)
      for (int bx = 0; bx < NB; bx++) begin
        int cc = X + 16 * bx + 15;
        int cl = Y + 16 * by + 15;
        if (cc < v.line_len && cl < v.n_lines && (abort_line < 0 || cl < abort_line)) begin
          int s = 0;
          for (int l = cl - 15; l <= cl; l++)
            for (int c = cc - 15; c <= cc; c++) s += int'(img[l][c]);
          exp_q.push_back(12'(s / 256));
        end
      end
    got_strobes = 0;
    got_done    = 0;
    iFVAL = 1'b1;
    step();
    repeat (3) step();
    for (int l = 0; l < v.n_lines; l++) begin
      if (l == abort_line) begin
        do_reset();
        live = 1'b0;
      end
      for (int c = 0; c < v.line_len; c++) begin
        while (v.gap > 0 && $urandom_range(99) < v.gap) begin
          iLVAL = 1'b1; iDVAL = 1'b0; iDATA = 12'($urandom_range(4095));
          drv_corner = 1'b0; drv_done = 1'b0;
          step();
        end
        iLVAL = 1'b1; iDVAL = 1'b1; iDATA = img[l][c];
        drv_corner = live && (c >= X) && (c < X + 16 * NB) && (l >= Y) && (l < Y + 16 * NB)
                     && ((c - X) % 16 == 15) && ((l - Y) % 16 == 15);
        if (drv_corner) corners++;
        drv_done = drv_corner && (corners == NB * NB);
        step();
      end
      iLVAL = 1'b0; iDVAL = 1'b0; drv_corner = 1'b0; drv_done = 1'b0;
      repeat (4) step();
    end
    iFVAL = 1'b0;
    repeat (6) step();
    check({name, "_strobes"}, got_strobes, v.exp_strobes);
    check({name, "_done_count"}, got_done, v.exp_done);
    check({name, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    vec_t v_abort, v_after;
    vecs[0] = '{K_CONST, FW, FH, 0,  16, 1};
    vecs[1] = '{K_BX,    FW, FH, 0,  16, 1};
    vecs[2] = '{K_FFF,   FW, FH, 0,  16, 1};
    vecs[3] = '{K_ALT,   FW, FH, 50, 16, 1};
    vecs[4] = '{K_RAND,  FW, FH, 25, 16, 1};
    vecs[5] = '{K_RAND,  60, FH, 0,  12, 0};
    vecs[6] = '{K_RAND,  FW, 40, 0,  8,  0};
    vecs[7] = '{K_RAND,  FW, FH, 20, 16, 1};

    repeat (3) @(posedge pxlclk);
    #1;
    check("reset_fval", oFVAL, 0);
    check("reset_dval", oDVAL, 0);
    check("reset_data", oDATA, 0);
    check("reset_done", oFRAME_DONE, 0);
    rst_n = 1'b1;
    repeat (3) step();
    mon_en = 1'b1;

    foreach (vecs[i]) run_frame(vecs[i], -1, $sformatf("vec%0d", i));

    // Reset in the middle of a frame: block row 0 comes out, the rest of the frame is ignored.
    v_abort = '{K_RAND, FW, FH, 0, 4, 0};
    run_frame(v_abort, 30, "abort");
    v_after = '{K_CONST, FW, FH, 0, 16, 1};
    run_frame(v_after, -1, "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
